// File: rtl/rand_spawn_scheduler.sv
// Spawn scheduler: asks the LFSR source for a column at a fixed interval and
// rejects immediate repeats with bounded retries. It then offers the column and
// its x position to the game object spawner.
module rand_spawn_scheduler #(
    parameter int PERIOD    = 50,
    parameter int RAND_LAT  = 1,
    parameter int MAX_RETRY = 3,
    parameter int X_BASE    = 0,
    parameter int X_STEP    = 40
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic [3:0] rand_in_i,
    output logic       rand_req_o,
    output logic       spawn_valid_o,
    input  logic       spawn_ready_i,
    output logic [3:0] spawn_col_o,
    output logic [9:0] spawn_x_o,
    output logic [7:0] spawn_count_o
);

    localparam int TW = $clog2(PERIOD + 1);
    localparam int LW = $clog2(RAND_LAT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {IDLE, WAIT, REQ, SAMPLE, OFFER} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          have_last_q, have_last_d;
    logic [3:0]    last_col_q, last_col_d;
    logic [3:0]    col_q, col_d;
    logic [9:0]    x_q, x_d;
    logic [7:0]    count_q, count_d;
    logic [9:0]    x_calc;

    // Evaluating the sum in 10 bits gives the same result as truncating the full sum.
    assign x_calc = 10'(X_BASE) + 10'(rand_in_i) * 10'(X_STEP);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        lat_d       = lat_q;
        retry_d     = retry_q;
        have_last_d = have_last_q;
        last_col_d  = last_col_q;
        col_d       = col_q;
        x_d         = x_q;
        count_d     = count_q;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    timer_d = TW'(PERIOD - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (enable_i) begin
                    if (timer_q != '0) timer_d = timer_q - TW'(1);
                    else               state_d = REQ;
                end
            end
            REQ: begin
                lat_d   = LW'(RAND_LAT - 1);
                state_d = SAMPLE;
            end
            SAMPLE: begin
                if (lat_q != '0) begin
                    lat_d = lat_q - LW'(1);
                end else if (have_last_q && rand_in_i == last_col_q &&
                             retry_q < RW'(MAX_RETRY)) begin
                    retry_d = retry_q + RW'(1);
                    state_d = REQ;
                end else begin
                    col_d       = rand_in_i;
                    x_d         = x_calc;
                    last_col_d  = rand_in_i;
                    have_last_d = 1'b1;
                    retry_d     = '0;
                    state_d     = OFFER;
                end
            end
            OFFER: begin
                if (spawn_ready_i) begin
                    if (count_q != 8'hFF) count_d = count_q + 8'd1;
                    timer_d = TW'(PERIOD - 1);
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            lat_q       <= '0;
            retry_q     <= '0;
            have_last_q <= 1'b0;
            last_col_q  <= '0;
            col_q       <= '0;
            x_q         <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            lat_q       <= lat_d;
            retry_q     <= retry_d;
            have_last_q <= have_last_d;
            last_col_q  <= last_col_d;
            col_q       <= col_d;
            x_q         <= x_d;
            count_q     <= count_d;
        end
    end

    assign rand_req_o    = (state_q == REQ);
    assign spawn_valid_o = (state_q == OFFER);
    assign spawn_col_o   = col_q;
    assign spawn_x_o     = x_q;
    assign spawn_count_o = count_q;

endmodule
